// File: rtl/regfile_writeback.sv
// Writeback buffer between the ALU/memory producers and the register file write port.
// Optional bypass lookup compiled in with REGFILE_WB_BYPASS_EN; without it the hit/data outputs are tied to 0.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          wb_stall,
  output logic          reg_write,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] busW,
  input  logic [AW-1:0] qa,
  input  logic [AW-1:0] qb,
  output logic          qa_hit,
  output logic          qb_hit,
  output logic [DW-1:0] qa_data,
  output logic [DW-1:0] qb_data,
  output logic          busy,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_reg_write;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_busw;
  logic [AW-1:0] r_fifo_rd  [DEPTH];
  logic [DW-1:0] r_fifo_dat [DEPTH];

  logic          w_full;
  logic          w_acc;
  logic [AW-1:0] w_acc_rd;
  logic [DW-1:0] w_acc_dat;
  logic          w_push;
  logic          w_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign mem_ready = !w_full;
  assign alu_ready = !w_full && !mem_valid;

  // Memory side wins arbitration; writes to x0 are acknowledged but dropped.
  assign w_acc     = !w_full && (mem_valid || alu_valid);
  assign w_acc_rd  = mem_valid ? mem_rd   : alu_rd;
  assign w_acc_dat = mem_valid ? mem_data : alu_data;
  assign w_push    = w_acc && (w_acc_rd != '0);
  assign w_pop     = !wb_stall && (r_count != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_reg_write <= 1'b0;
      r_rw        <= '0;
      r_busw      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_rw   <= r_fifo_rd[r_rd_ptr];
        r_busw <= r_fifo_dat[r_rd_ptr];
      end
    end
  end

  // Entry storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]  <= w_acc_rd;
      r_fifo_dat[r_wr_ptr] <= w_acc_dat;
    end
  end

  assign reg_write = r_reg_write;
  assign rw        = r_rw;
  assign busW      = r_busw;
  assign busy      = (r_count != '0) || r_reg_write;
  assign full      = w_full;

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the tail-most match overrides; the output register is the oldest candidate.
  function automatic logic [DW:0] f_lookup(input logic [AW-1:0] q);
    logic          hit;
    logic [DW-1:0] dat;
    logic [PW-1:0] idx;
    hit = r_reg_write && (r_rw == q);
    dat = r_busw;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_fifo_rd[idx] == q)) begin
        hit = 1'b1;
        dat = r_fifo_dat[idx];
      end
    end
    if ((q == '0) || !hit) begin
      hit = 1'b0;
      dat = '0;
    end
    return {hit, dat};
  endfunction

  logic [DW:0] w_qa_res;
  logic [DW:0] w_qb_res;

  always_comb begin
    w_qa_res = f_lookup(qa);
    w_qb_res = f_lookup(qb);
  end

  assign qa_hit  = w_qa_res[DW];
  assign qa_data = w_qa_res[DW-1:0];
  assign qb_hit  = w_qb_res[DW];
  assign qb_data = w_qb_res[DW-1:0];
`else
  logic w_unused_q;
  assign w_unused_q = ^{qa, qb};
  assign qa_hit     = 1'b0;
  assign qb_hit     = 1'b0;
  assign qa_data    = '0;
  assign qb_data    = '0;
`endif

endmodule
